seven_seg_display: RTL and testbench

//  Downstream consumer of the minutes/seconds counter: time-multiplexes the four BCD digits
//  (min1 min0 : sec1 sec0) onto a 4-digit common-anode 7-segment display. Blinks the field

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seven_seg_display_bcd_to_seg.sv | 17 +
 rtl/seven_seg_display.sv | 97 +++++++++
 tb/tb_seven_seg_display.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for 7-segment display blocks: active-low segment patterns,
// anode/blank codes, digit scan indices and adjust-mode encodings.
package seven_seg_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [1:0] IDX_SEC0 = 2'd0;
    localparam logic [1:0] IDX_SEC1 = 2'd1;
    localparam logic [1:0] IDX_MIN0 = 2'd2;
    localparam logic [1:0] IDX_MIN1 = 2'd3;

    localparam logic [1:0] ADJ_RUN = 2'd0;
    localparam logic [1:0] ADJ_INC = 2'd1;
    localparam logic [1:0] ADJ_DEC = 2'd2;

endpackage

// File: rtl/seven_seg_display_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 are blanked
// so a corrupted digit never shows as a misleading glyph.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seven_seg_display.sv
// Four-digit multiplexed mm:ss display driver with blinking of the field under
// adjustment and a separator dot after the minutes units digit.
module seven_seg_display
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [1:0] adjust,
    input  logic       select,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             refresh_wrap;
    logic             blink_wrap;
    logic             adj_active;
    logic             sec_field;
    logic             blank;
    logic [3:0]       digit_bcd;

    bcd_to_seg u_dec (
        .bcd (digit_bcd),
        .seg (seg_d)
    );

    always_comb begin
        refresh_wrap  = (refresh_cnt_q == REF_W'(REFRESH_DIV - 1));
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + REF_W'(1);
        digit_idx_d   = refresh_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

        // Leaving adjust mode clears the blink state so re-entry starts visible.
        adj_active    = (adjust == ADJ_INC) || (adjust == ADJ_DEC);
        blink_wrap    = (blink_cnt_q == BLK_W'(BLINK_DIV - 1));
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (adj_active) begin
            blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLK_W'(1);
            blink_phase_d = blink_phase_q ^ blink_wrap;
        end

        case (digit_idx_q)
            IDX_SEC0: digit_bcd = sec0;
            IDX_SEC1: digit_bcd = sec1;
            IDX_MIN0: digit_bcd = min0;
            default:  digit_bcd = min1;
        endcase

        sec_field = (digit_idx_q == IDX_SEC0) || (digit_idx_q == IDX_SEC1);
        blank     = adj_active && blink_phase_q && (select == sec_field);
        an_d      = blank ? AN_OFF : ~(4'b0001 << digit_idx_q);
        dp_d      = !((digit_idx_q == IDX_MIN0) && !blank);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= IDX_SEC0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display with a fast refresh (4) and blink (8) divider.
module tb_seven_seg_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] min1, min0, sec1, sec0;
    logic [1:0] adjust;
    logic       select;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    seven_seg_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .min1   (min1),
        .min0   (min0),
        .sec1   (sec1),
        .sec0   (sec0),
        .adjust (adjust),
        .select (select),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] an_of(int idx);
        case (idx)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // Segments for the display value 12:34, indexed by scan slot.
    function automatic logic [6:0] seg_1234(int idx);
        case (idx)
            0:       return 7'b0011001;
            1:       return 7'b0110000;
            2:       return 7'b0100100;
            default: return 7'b1111001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] adj, input logic sel);
        min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
        adjust = adj; select = sel;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
        adjust = 2'd0; select = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reset_an actual=%b required=1111", an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg actual=%b required=1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b required=1", dp); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        do_reset(2'd0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            int idx;
            tick();
            idx = ((n - 1) / 4) % 4;
            checks++;
            if (an !== an_of(idx)) begin errors++; $display("FAIL scan_an edge=%0d actual=%b required=%b", n, an, an_of(idx)); end
            checks++;
            if (seg !== seg_1234(idx)) begin errors++; $display("FAIL scan_seg edge=%0d actual=%b required=%b", n, seg, seg_1234(idx)); end
            checks++;
            if (dp !== (idx != 2)) begin errors++; $display("FAIL scan_dp edge=%0d actual=%b required=%b", n, dp, (idx != 2)); end
        end
    endtask

    task automatic test_illegal_bcd();
        do_reset(2'd0, 1'b0);
        sec0 = 4'hC;
        for (int n = 1; n <= 16; n++) begin
            int idx;
            logic [6:0] exp_seg;
            tick();
            idx = ((n - 1) / 4) % 4;
            exp_seg = (idx == 0) ? 7'h7F : seg_1234(idx);
            checks++;
            if (seg !== exp_seg) begin errors++; $display("FAIL illegal_seg edge=%0d actual=%b required=%b", n, seg, exp_seg); end
            checks++;
            if (an !== an_of(idx)) begin errors++; $display("FAIL illegal_an edge=%0d actual=%b required=%b", n, an, an_of(idx)); end
        end
    endtask

    // Adjust starts at the idx2 slot, so the off phase lands on the seconds slots.
    task automatic test_blink();
        do_reset(2'd0, 1'b1);
        for (int n = 1; n <= 8; n++) tick();
        adjust = 2'd1;
        for (int n = 9; n <= 40; n++) begin
            int idx;
            logic blank;
            logic [3:0] exp_an;
            tick();
            idx = ((n - 1) / 4) % 4;
            blank = (n >= 17) && ((((n - 17) / 8) % 2) == 0) && (idx < 2);
            exp_an = blank ? 4'b1111 : an_of(idx);
            checks++;
            if (an !== exp_an) begin errors++; $display("FAIL blink_an edge=%0d actual=%b required=%b", n, an, exp_an); end
            checks++;
            if (dp !== !((idx == 2) && !blank)) begin errors++; $display("FAIL blink_dp edge=%0d actual=%b required=%b", n, dp, !((idx == 2) && !blank)); end
        end
    endtask

    task automatic test_select_toggle();
        logic [3:0] exp_an [13:21];
        exp_an[13] = 4'b1111; exp_an[14] = 4'b1111;
        exp_an[15] = 4'b0111; exp_an[16] = 4'b0111;
        exp_an[17] = 4'b1111; exp_an[18] = 4'b1111;
        exp_an[19] = 4'b1111; exp_an[20] = 4'b1111;
        exp_an[21] = 4'b1101;
        do_reset(2'd0, 1'b0);
        for (int n = 1; n <= 4; n++) tick();
        adjust = 2'd2;
        for (int n = 5; n <= 12; n++) tick();
        for (int n = 13; n <= 21; n++) begin
            tick();
            if (n == 14) select = 1'b1;
            checks++;
            if (an !== exp_an[n]) begin errors++; $display("FAIL select_an edge=%0d actual=%b required=%b", n, an, exp_an[n]); end
        end
    endtask

    task automatic test_adjust_exit();
        do_reset(2'd1, 1'b0);
        for (int n = 1; n <= 10; n++) tick();
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL exit_pre_an actual=%b required=1111", an); end
        adjust = 2'd0;
        tick();
        checks++;
        if (an !== 4'b1011) begin errors++; $display("FAIL exit_an actual=%b required=1011", an); end
        checks++;
        if (dp !== 1'b0) begin errors++; $display("FAIL exit_dp actual=%b required=0", dp); end
        checks++;
        if (dut.blink_cnt_q !== '0) begin errors++; $display("FAIL exit_blink_cnt actual=%0d required=0", dut.blink_cnt_q); end
        checks++;
        if (dut.blink_phase_q !== 1'b0) begin errors++; $display("FAIL exit_blink_phase actual=%b required=0", dut.blink_phase_q); end
        adjust = 2'd1;
        for (int n = 12; n <= 16; n++) begin
            int idx;
            tick();
            idx = ((n - 1) / 4) % 4;
            checks++;
            if (an !== an_of(idx)) begin errors++; $display("FAIL reenter_an edge=%0d actual=%b required=%b", n, an, an_of(idx)); end
        end
        for (int n = 17; n <= 25; n++) tick();
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reenter_blank_an actual=%b required=1111", an); end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd0, 1'b0);
        for (int n = 1; n <= 10; n++) tick();
        checks++;
        if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an actual=%b required=1011", an); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL mid_an actual=%b required=1111", an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL mid_seg actual=%b required=1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL mid_dp actual=%b required=1", dp); end
        for (int n = 1; n <= 5; n++) begin
            logic [3:0] exp_an;
            tick();
            exp_an = (n <= 4) ? 4'b1110 : 4'b1101;
            checks++;
            if (an !== exp_an) begin errors++; $display("FAIL mid_after_an edge=%0d actual=%b required=%b", n, an, exp_an); end
        end
    endtask

    initial begin
        reset = 1'b1;
        min1 = '0; min0 = '0; sec1 = '0; sec0 = '0;
        adjust = '0; select = 1'b0;
        #1;
        test_reset();
        test_scan();
        test_illegal_bcd();
        test_blink();
        test_select_toggle();
        test_adjust_exit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
